// File: rtl/pio_step_responder.sv
// -----------------------------------------------------------------------------
// pio_step_responder
//   Executes stepper commands that the HPS sends through the gpio0 PIO output
//   word, and reports acknowledge/status back through the gpio0 PIO input word.
//   Produces step/dir for one axis driver and stops on a min-endstop.
//
// Ports
//   clk_clk        system clock, shared with the PIO
//   reset_reset_n  asynchronous active-low reset
//   cmd_in[31:0]   command word: [31] req toggle, [30:29] opcode,
//                  [28] dir (MOVE), [15:0] arg (steps or period)
//   rsp_out[31:0]  status word: [31] ack, [30] busy, [29] err, [28] dir,
//                  [27] endstop_hit, [15:0] steps_rem
//   endstop        min-endstop, active high, asynchronous
//   step           step pulse, PULSE_W clocks high
//   dir            direction, 1 = positive
// -----------------------------------------------------------------------------
module pio_step_responder #(
    parameter int PULSE_W    = 20,
    parameter int DIR_SETUP  = 10,
    parameter int PERIOD_RST = 1000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] cmd_in,
    output logic [31:0] rsp_out,
    input  logic        endstop,
    output logic        step,
    output logic        dir
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_GAP} state_e;
    typedef enum logic [1:0] {
        OP_STATUS     = 2'b00,
        OP_MOVE       = 2'b01,
        OP_ABORT      = 2'b10,
        OP_SET_PERIOD = 2'b11
    } opcode_e;

    // Counters load "length - 1" and the state advances on the edge after 0.
    localparam logic [15:0] SETUP_LAST = 16'(DIR_SETUP - 1);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_W - 1);
    localparam logic [15:0] PERIOD_MIN = 16'(PULSE_W + 1);

    logic [3:0]  cmd_hdr_q;     // {req, opcode, dir} captured from cmd_in
    logic [15:0] cmd_arg_q;
    logic [1:0]  sync_q;        // endstop synchronizer, [1] is endstop_s

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] steps_rem_q, steps_rem_d;
    logic [15:0] period_q, period_d;
    logic        req_seen_q, req_seen_d;
    logic        err_q, err_d;
    logic        hit_q, hit_d;
    logic        dir_q, dir_d;
    logic        stop_pend_q, stop_pend_d;  // stop requested while a pulse is high
    logic        step_q, step_d;
    logic [31:0] rsp_q, rsp_d;

    logic        cmd_new;
    opcode_e     cmd_op;
    logic        cmd_dir;
    logic        endstop_s;
    logic        endstop_stop;
    logic        abort_now;

    // cmd_in[27:16] carry no meaning; folded here so they are visibly consumed.
    logic        unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_in[27:16];

    assign cmd_new      = cmd_hdr_q[3] != req_seen_q;
    assign cmd_op       = opcode_e'(cmd_hdr_q[2:1]);
    assign cmd_dir      = cmd_hdr_q[0];
    assign endstop_s    = sync_q[1];
    assign endstop_stop = endstop_s && !dir_q;
    assign abort_now    = cmd_new && (cmd_op == OP_ABORT);

    always_comb begin
        // NOTE: every _d starts from its _q so no branch below can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        steps_rem_d = steps_rem_q;
        period_d    = period_q;
        req_seen_d  = req_seen_q;
        err_d       = err_q;
        hit_d       = hit_q;
        dir_d       = dir_q;
        stop_pend_d = stop_pend_q;

        // Command decode. ABORT only acts on the motion FSM below.
        if (cmd_new) begin
            req_seen_d = cmd_hdr_q[3];
            case (cmd_op)
                OP_STATUS: begin
                    err_d = 1'b0;
                    hit_d = 1'b0;
                end
                OP_MOVE: begin
                    if (state_q != ST_IDLE) begin
                        err_d = 1'b1;
                    end else if (cmd_arg_q != 16'd0) begin
                        if (!cmd_dir && endstop_s) begin
                            hit_d = 1'b1;
                        end else begin
                            dir_d       = cmd_dir;
                            steps_rem_d = cmd_arg_q;
                            cnt_d       = SETUP_LAST;
                            state_d     = ST_SETUP;
                        end
                    end
                end
                OP_SET_PERIOD: begin
                    if (state_q != ST_IDLE) begin
                        err_d = 1'b1;
                    end else begin
                        period_d = (cmd_arg_q < PERIOD_MIN) ? PERIOD_MIN : cmd_arg_q;
                    end
                end
                default: ;
            endcase
        end

        // Motion FSM. A MOVE is only accepted from IDLE, so the two halves
        // never both drive state_d in the same cycle.
        case (state_q)
            ST_SETUP, ST_GAP: begin
                if (abort_now || endstop_stop) begin
                    state_d     = ST_IDLE;
                    steps_rem_d = 16'd0;
                    if (!abort_now) hit_d = 1'b1;   // ABORT wins over endstop
                end else if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (state_q == ST_SETUP || steps_rem_q != 16'd0) begin
                    state_d     = ST_PULSE;
                    cnt_d       = PULSE_LAST;
                    steps_rem_d = steps_rem_q - 16'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                // A pulse always runs its full width; stops take effect after it.
                if (abort_now) begin
                    stop_pend_d = 1'b1;
                end else if (endstop_stop) begin
                    stop_pend_d = 1'b1;
                    hit_d       = 1'b1;
                end
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (stop_pend_d) begin
                    state_d     = ST_IDLE;
                    steps_rem_d = 16'd0;
                    stop_pend_d = 1'b0;
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = period_q - PERIOD_MIN;    // GAP lasts period - PULSE_W
                end
            end
            default: ;
        endcase

        // Outputs are registered from next-state values, so they change on the
        // same edge as the state and nothing from cmd_in reaches them directly.
        step_d = (state_d == ST_PULSE);
        rsp_d  = {req_seen_d, state_d != ST_IDLE, err_d, dir_d, hit_d, 11'd0, steps_rem_d};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd_hdr_q   <= 4'd0;
            cmd_arg_q   <= 16'd0;
            sync_q      <= 2'b00;
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            steps_rem_q <= 16'd0;
            period_q    <= 16'(PERIOD_RST);
            req_seen_q  <= 1'b0;
            err_q       <= 1'b0;
            hit_q       <= 1'b0;
            dir_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            step_q      <= 1'b0;
            rsp_q       <= 32'd0;
        end else begin
            cmd_hdr_q   <= cmd_in[31:28];
            cmd_arg_q   <= cmd_in[15:0];
            sync_q      <= {sync_q[0], endstop};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            steps_rem_q <= steps_rem_d;
            period_q    <= period_d;
            req_seen_q  <= req_seen_d;
            err_q       <= err_d;
            hit_q       <= hit_d;
            dir_q       <= dir_d;
            stop_pend_q <= stop_pend_d;
            step_q      <= step_d;
            rsp_q       <= rsp_d;
        end
    end

    assign rsp_out = rsp_q;
    assign step    = step_q;
    assign dir     = dir_q;

endmodule

// File: tb/tb_pio_step_responder.sv
// -----------------------------------------------------------------------------
// tb_pio_step_responder
//   Self-checking bench for pio_step_responder. A small command-level model
//   tracks ack/err/endstop_hit/dir/period; pulse trains are predicted from the
//   timing rules (first rise, period spacing, pulse width, busy release) and
//   compared with step edges observed on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pio_step_responder;

    localparam int PULSE_W    = 20;
    localparam int DIR_SETUP  = 10;
    localparam int PERIOD_RST = 1000;

    localparam logic [1:0] OP_STATUS = 2'b00;
    localparam logic [1:0] OP_MOVE   = 2'b01;
    localparam logic [1:0] OP_ABORT  = 2'b10;
    localparam logic [1:0] OP_SETP   = 2'b11;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [31:0] cmd_in = 32'd0;
    logic        endstop = 1'b0;
    logic [31:0] rsp_out;
    logic        step;
    logic        dir;

    pio_step_responder #(
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP),
        .PERIOD_RST(PERIOD_RST)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .cmd_in       (cmd_in),
        .rsp_out      (rsp_out),
        .endstop      (endstop),
        .step         (step),
        .dir          (dir)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Command-level reference model
    logic m_req    = 1'b0;
    logic m_err    = 1'b0;
    logic m_hit    = 1'b0;
    logic m_dir    = 1'b0;
    int   m_period = PERIOD_RST;

    // Injection schedule used while watching a move
    int         inj_at = -1;
    logic [1:0] inj_op = OP_STATUS;
    logic       inj_dir = 1'b0;
    logic [15:0] inj_arg = 16'd0;
    int         es_at = -1;

    int rise_q[$];
    int fall_q[$];
    int rem_q[$];

    function automatic logic [31:0] model_word(input logic busy, input logic [15:0] rem);
        return {m_req, busy, m_err, m_dir, m_hit, 11'd0, rem};
    endfunction

    // Drive one command (caller sits on a falling edge) and apply it to the model.
    task automatic send(input logic [1:0] op, input logic d, input logic [15:0] arg,
                        input bit busy, output int c, output bit started);
        m_req   = ~m_req;
        cmd_in  = {m_req, op, d, 12'd0, arg};
        c       = cyc;
        started = 1'b0;
        case (op)
            OP_STATUS: begin
                m_err = 1'b0;
                m_hit = 1'b0;
            end
            OP_MOVE: begin
                if (busy) m_err = 1'b1;
                else if (arg != 16'd0) begin
                    if (!d && endstop) m_hit = 1'b1;
                    else begin
                        m_dir   = d;
                        started = 1'b1;
                    end
                end
            end
            OP_SETP: begin
                if (busy) m_err = 1'b1;
                else m_period = (int'(arg) < PULSE_W + 1) ? PULSE_W + 1 : int'(arg);
            end
            default: ;
        endcase
    endtask

    // Send while idle and wait until the response for it is visible.
    task automatic issue(input logic [1:0] op, input logic d, input logic [15:0] arg,
                         output int c, output bit started);
        send(op, d, arg, 1'b0, c, started);
        repeat (2) @(negedge clk_clk);
    endtask

    // Observe a move until busy drops, then compare with the predicted train.
    task automatic watch(input string tag, input int budget, input int n_rises,
                         input int steps_total, input int first, input int period,
                         input int exp_idle);
        logic prev;
        int   idle_at;
        int   c;
        bit   st;
        int   got_fall;
        rise_q.delete();
        fall_q.delete();
        rem_q.delete();
        idle_at = -1;
        prev    = step;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_clk);
            if (step && !prev) begin
                rise_q.push_back(cyc);
                rem_q.push_back(int'(rsp_out[15:0]));
            end
            if (!step && prev) fall_q.push_back(cyc);
            prev = step;
            if (!rsp_out[30]) begin
                idle_at = cyc;
                break;
            end
            if (cyc == inj_at) send(inj_op, inj_dir, inj_arg, 1'b1, c, st);
            if (cyc == es_at) endstop = 1'b1;
        end
        inj_at = -1;
        es_at  = -1;

        chk_cnt++;
        if (rise_q.size() != n_rises)
            $display("FAIL %s rise_count got=%0d exp=%0d", tag, rise_q.size(), n_rises);
        else pass_cnt++;
        for (int k = 0; k < rise_q.size() && k < n_rises; k++) begin
            chk_cnt++;
            if (rise_q[k] != first + k * period)
                $display("FAIL %s rise%0d_cycle got=%0d exp=%0d", tag, k, rise_q[k], first + k * period);
            else pass_cnt++;
            got_fall = (k < fall_q.size()) ? fall_q[k] : -1;
            chk_cnt++;
            if (got_fall != rise_q[k] + PULSE_W)
                $display("FAIL %s fall%0d_cycle got=%0d exp=%0d", tag, k, got_fall, rise_q[k] + PULSE_W);
            else pass_cnt++;
            chk_cnt++;
            if (rem_q[k] != steps_total - 1 - k)
                $display("FAIL %s steps_rem%0d got=%0d exp=%0d", tag, k, rem_q[k], steps_total - 1 - k);
            else pass_cnt++;
        end
        chk_cnt++;
        if (idle_at != exp_idle)
            $display("FAIL %s busy_fall_cycle got=%0d exp=%0d", tag, idle_at, exp_idle);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        cmd_in        = 32'd0;
        endstop       = 1'b0;
        repeat (3) @(negedge clk_clk);
        chk_cnt++;
        if (step !== 1'b0 || rsp_out !== 32'd0)
            $display("FAIL reset_hold step=%b rsp=%h exp step=0 rsp=0", step, rsp_out);
        else pass_cnt++;
        reset_reset_n = 1'b1;
        repeat (4) @(negedge clk_clk);
        chk_cnt++;
        if (rsp_out !== 32'd0) $display("FAIL reset_rsp got=%h exp=00000000", rsp_out);
        else pass_cnt++;
        chk_cnt++;
        if (step !== 1'b0 || dir !== 1'b0) $display("FAIL reset_step_dir got=%b%b exp=00", step, dir);
        else pass_cnt++;
    endtask

    task automatic test_default_period();
        int c;
        bit st;
        issue(OP_MOVE, 1'b1, 16'd1, c, st);
        chk_cnt++;
        if (rsp_out !== model_word(1'b1, 16'd1))
            $display("FAIL default_move_accept got=%h exp=%h", rsp_out, model_word(1'b1, 16'd1));
        else pass_cnt++;
        watch("default_period", 1100, 1, 1, c + 2 + DIR_SETUP, m_period, c + 2 + DIR_SETUP + m_period);
    endtask

    task automatic test_move_basic();
        int c;
        bit st;
        int first;
        issue(OP_SETP, 1'b0, 16'd100, c, st);
        chk_cnt++;
        if (rsp_out !== model_word(1'b0, 16'd0))
            $display("FAIL basic_setp got=%h exp=%h", rsp_out, model_word(1'b0, 16'd0));
        else pass_cnt++;
        issue(OP_MOVE, 1'b1, 16'd3, c, st);
        chk_cnt++;
        if (rsp_out !== model_word(1'b1, 16'd3) || dir !== 1'b1)
            $display("FAIL basic_move_accept got=%h dir=%b exp=%h dir=1", rsp_out, dir, model_word(1'b1, 16'd3));
        else pass_cnt++;
        first = c + 2 + DIR_SETUP;
        watch("basic_train", 500, 3, 3, first, 100, first + 3 * 100);
        chk_cnt++;
        if (rsp_out !== model_word(1'b0, 16'd0))
            $display("FAIL basic_done got=%h exp=%h", rsp_out, model_word(1'b0, 16'd0));
        else pass_cnt++;
    endtask

    task automatic test_move_while_busy();
        int c;
        bit st;
        int first;
        issue(OP_MOVE, 1'b1, 16'd3, c, st);
        first   = c + 2 + DIR_SETUP;
        inj_at  = first + 30;
        inj_op  = OP_MOVE;
        inj_dir = 1'b0;
        inj_arg = 16'd7;
        watch("busy_train", 500, 3, 3, first, m_period, first + 3 * m_period);
        chk_cnt++;
        if (rsp_out !== model_word(1'b0, 16'd0))
            $display("FAIL busy_err_set got=%h exp=%h", rsp_out, model_word(1'b0, 16'd0));
        else pass_cnt++;
        issue(OP_STATUS, 1'b0, 16'd0, c, st);
        chk_cnt++;
        if (rsp_out !== model_word(1'b0, 16'd0))
            $display("FAIL status_clear got=%h exp=%h", rsp_out, model_word(1'b0, 16'd0));
        else pass_cnt++;
    endtask

    task automatic test_clamp();
        int c;
        bit st;
        int first;
        issue(OP_SETP, 1'b0, 16'd5, c, st);
        issue(OP_MOVE, 1'b1, 16'd4, c, st);
        first = c + 2 + DIR_SETUP;
        watch("clamp_train", 300, 4, 4, first, PULSE_W + 1, first + 4 * (PULSE_W + 1));
    endtask

    task automatic test_endstop();
        int c;
        bit st;
        int first;
        int n_rise;
        issue(OP_SETP, 1'b0, 16'd100, c, st);
        issue(OP_MOVE, 1'b0, 16'd1000, c, st);
        first = c + 2 + DIR_SETUP;
        es_at = first + 40;
        watch("endstop_gap", 300, 1, 1000, first, 100, first + 43);
        m_hit = 1'b1;
        chk_cnt++;
        if (rsp_out !== model_word(1'b0, 16'd0) || step !== 1'b0)
            $display("FAIL endstop_gap_status got=%h step=%b exp=%h step=0", rsp_out, step, model_word(1'b0, 16'd0));
        else pass_cnt++;

        // Endstop still high: clear status, then a negative MOVE must be refused.
        issue(OP_STATUS, 1'b0, 16'd0, c, st);
        issue(OP_MOVE, 1'b0, 16'd5, c, st);
        chk_cnt++;
        if (rsp_out !== model_word(1'b0, 16'd0))
            $display("FAIL endstop_reject got=%h exp=%h", rsp_out, model_word(1'b0, 16'd0));
        else pass_cnt++;
        n_rise = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_clk);
            if (step) n_rise++;
        end
        chk_cnt++;
        if (n_rise != 0) $display("FAIL endstop_reject_pulses got=%0d exp=0", n_rise);
        else pass_cnt++;

        // A positive move away from the min endstop still runs.
        issue(OP_MOVE, 1'b1, 16'd1, c, st);
        first = c + 2 + DIR_SETUP;
        watch("endstop_positive", 300, 1, 1, first, 100, first + 100);
        endstop = 1'b0;
        repeat (3) @(negedge clk_clk);
    endtask

    task automatic test_abort();
        int c;
        bit st;
        int first;
        issue(OP_MOVE, 1'b1, 16'd5, c, st);
        first   = c + 2 + DIR_SETUP;
        inj_at  = first + 5;
        inj_op  = OP_ABORT;
        inj_dir = 1'b0;
        inj_arg = 16'd0;
        watch("abort_pulse", 300, 1, 5, first, m_period, first + PULSE_W);
        chk_cnt++;
        if (rsp_out !== model_word(1'b0, 16'd0))
            $display("FAIL abort_status got=%h exp=%h", rsp_out, model_word(1'b0, 16'd0));
        else pass_cnt++;
        issue(OP_ABORT, 1'b0, 16'd0, c, st);
        chk_cnt++;
        if (rsp_out !== model_word(1'b0, 16'd0))
            $display("FAIL abort_idle got=%h exp=%h", rsp_out, model_word(1'b0, 16'd0));
        else pass_cnt++;
    endtask

    task automatic test_zero_move();
        int c;
        bit st;
        issue(OP_MOVE, 1'b0, 16'd0, c, st);
        repeat (DIR_SETUP + 2) @(negedge clk_clk);
        chk_cnt++;
        if (rsp_out !== model_word(1'b0, 16'd0) || step !== 1'b0)
            $display("FAIL zero_move got=%h step=%b exp=%h step=0", rsp_out, step, model_word(1'b0, 16'd0));
        else pass_cnt++;
    endtask

    task automatic test_random();
        int          c;
        bit          st;
        int          first;
        int          n;
        logic        d;
        logic [15:0] p;
        for (int it = 0; it < 8; it++) begin
            p = 16'($urandom_range(0, 150));
            issue(OP_SETP, 1'b0, p, c, st);
            chk_cnt++;
            if (rsp_out !== model_word(1'b0, 16'd0))
                $display("FAIL rand%0d_setp got=%h exp=%h", it, rsp_out, model_word(1'b0, 16'd0));
            else pass_cnt++;
            d = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 4);
            issue(OP_MOVE, d, 16'(n), c, st);
            chk_cnt++;
            if (rsp_out !== model_word(1'b1, 16'(n)))
                $display("FAIL rand%0d_move got=%h exp=%h", it, rsp_out, model_word(1'b1, 16'(n)));
            else pass_cnt++;
            first = c + 2 + DIR_SETUP;
            if (it % 2 == 1) begin
                inj_at  = first + 3;
                inj_op  = OP_SETP;
                inj_dir = 1'b0;
                inj_arg = 16'($urandom_range(0, 150));
            end
            watch($sformatf("rand%0d_train", it), 800, n, n, first, m_period, first + n * m_period);
            chk_cnt++;
            if (rsp_out !== model_word(1'b0, 16'd0))
                $display("FAIL rand%0d_done got=%h exp=%h", it, rsp_out, model_word(1'b0, 16'd0));
            else pass_cnt++;
            issue(OP_STATUS, 1'b0, 16'd0, c, st);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int c;
        bit st;
        bit seen;
        issue(OP_MOVE, 1'b1, 16'd3, c, st);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_clk);
            if (step) seen = 1'b1;
        end
        chk_cnt++;
        if (!seen) $display("FAIL rst_mid_wait_step got=0 exp=1");
        else pass_cnt++;
        #2 reset_reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (step !== 1'b0 || rsp_out !== 32'd0 || dir !== 1'b0)
            $display("FAIL rst_mid_async step=%b dir=%b rsp=%h exp 0 0 00000000", step, dir, rsp_out);
        else pass_cnt++;
        cmd_in   = 32'd0;
        m_req    = 1'b0;
        m_err    = 1'b0;
        m_hit    = 1'b0;
        m_dir    = 1'b0;
        m_period = PERIOD_RST;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_clk);
        chk_cnt++;
        if (rsp_out !== model_word(1'b0, 16'd0) || step !== 1'b0)
            $display("FAIL rst_mid_release got=%h step=%b exp=%h step=0", rsp_out, step, model_word(1'b0, 16'd0));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_move_basic();
        test_move_while_busy();
        test_clamp();
        test_endstop();
        test_abort();
        test_zero_move();
        test_random();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
